l2_req_responder: RTL and testbench



---
 rtl/l2_if_pkg.sv | 39 +++
 rtl/l2_resp_mem.sv | 46 ++++
 rtl/l2_req_responder.sv | 185 ++++++++++++++++++
 tb/tb_l2_req_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_if_pkg.sv
// Shared types and helpers for the L1-to-L2 request interface.
package l2_if_pkg;

  localparam int LINE_BYTES = 32;

  typedef enum logic [1:0] {
    CMD_RD = 2'b00,
    CMD_WR = 2'b01
  } l2_cmd_e;

  typedef enum logic [2:0] {
    SZ_1B  = 3'd0,
    SZ_2B  = 3'd1,
    SZ_4B  = 3'd2,
    SZ_8B  = 3'd3,
    SZ_16B = 3'd4,
    SZ_32B = 3'd5
  } l2_size_e;

  // Word beats for a request size; illegal sizes collapse to a single beat
  // so an errored write still has a bounded number of beats to drain.
  function automatic logic [3:0] beats_from_size(input logic [2:0] size);
    case (size)
      SZ_8B:   return 4'd2;
      SZ_16B:  return 4'd4;
      SZ_32B:  return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  // Low address bits that must be zero: alignment to min(2^size, line).
  function automatic logic [4:0] align_mask(input logic [2:0] size);
    int bytes;
    bytes = 1 << size;
    if (bytes > LINE_BYTES) bytes = LINE_BYTES;
    return 5'(bytes - 1);
  endfunction

endpackage

// File: rtl/l2_resp_mem.sv
// Single-port word SRAM model: byte write enables, one-cycle registered read.
module l2_resp_mem
  import l2_if_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int SW    = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [SW-1:0] wstrb,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_array [WORDS];
  logic [DW-1:0] rdata_d, rdata_q;

  // Read port holds its last value when not reading.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_array[addr];
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  // Byte-masked write; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb[b]) mem_array[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l2_req_responder.sv
// L2 responder for L1 read/write requests, backed by an internal word memory.
// Optional macro L2_RESP_ERR_INJ_EN adds the err_inject input.
//
// state  | meaning
// IDLE   | waiting for req_val, decodes and captures the request
// WAIT   | read latency down-count before the first beat
// RDATA  | one read beat per cycle, resp_val with the last
// WDATA  | consume write beats on req_wdata_val
// RESP   | one-cycle resp_val (write done or any error)
// GAP    | initiator turnaround, req_val ignored
module l2_req_responder
  import l2_if_pkg::*;
#(
  parameter int L2_CMND_WIDTH = 2,
  parameter int L2_SIZE_WIDTH = 3,
  parameter int L2_ADDR_WIDTH = 16,
  parameter int L2_DATA_WIDTH = 32,
  parameter int L2_STRB_WIDTH = L2_DATA_WIDTH / 8,
  parameter int MEM_WORDS     = 1024,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef L2_RESP_ERR_INJ_EN
  input  logic                     err_inject,
`endif
  input  logic                     req_val,
  input  logic                     req_nc,
  input  logic [L2_CMND_WIDTH-1:0] req_cmd,
  input  logic [L2_SIZE_WIDTH-1:0] req_size,
  input  logic [L2_ADDR_WIDTH-1:0] req_addr,
  input  logic                     req_wdata_val,
  input  logic [L2_DATA_WIDTH-1:0] req_wdata,
  input  logic [L2_STRB_WIDTH-1:0] req_wstrb,
  output logic                     resp_val,
  output logic                     resp_err,
  output logic                     resp_rdata_val,
  output logic [L2_DATA_WIDTH-1:0] resp_rdata
);

  localparam int MAW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_RDATA, ST_WDATA, ST_RESP, ST_GAP
  } state_e;

  state_e             state_d, state_q;
  logic               err_d, err_q;
  logic [3:0]         beats_d, beats_q;
  logic [3:0]         wait_d, wait_q;
  logic [MAW-1:0]     word_d, word_q;

  logic [3:0]         req_beats;
  logic [MAW-1:0]     req_word;
  logic [31:0]        last_word;
  logic               req_err;

  logic               mem_en, mem_we;
  logic [MAW-1:0]     mem_addr;
  logic [L2_DATA_WIDTH-1:0] mem_rdata;

  // Request decode and error classification, only consumed in IDLE.
  always_comb begin
    req_beats = beats_from_size(req_size);
    req_word  = req_addr[MAW+1:2];
    last_word = 32'(req_addr[L2_ADDR_WIDTH-1:2]) + 32'(req_beats) - 32'd1;
    req_err   = 1'b0;
    if (req_cmd != CMD_RD && req_cmd != CMD_WR)          req_err = 1'b1;
    if (req_size > SZ_32B)                               req_err = 1'b1;
    if ((req_addr[4:0] & align_mask(req_size)) != 5'd0)  req_err = 1'b1;
    if (last_word >= 32'(MEM_WORDS))                     req_err = 1'b1;
    if (req_nc && req_size > SZ_4B)                      req_err = 1'b1;
`ifdef L2_RESP_ERR_INJ_EN
    if (err_inject)                                      req_err = 1'b1;
`endif
  end

  // Next-state and memory port control. A read is issued one cycle ahead of
  // each beat to absorb the memory's registered read.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    beats_d  = beats_q;
    wait_d   = wait_q;
    word_d   = word_q;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = word_q;
    case (state_q)
      ST_IDLE: begin
        if (req_val) begin
          err_d   = req_err;
          beats_d = req_beats;
          word_d  = req_word;
          if (req_cmd == CMD_WR) begin
            state_d = ST_WDATA;
          end else if (req_err) begin
            state_d = ST_RESP;
          end else if (RD_LATENCY == 0) begin
            state_d  = ST_RDATA;
            mem_en   = 1'b1;
            mem_addr = req_word;
          end else begin
            state_d = ST_WAIT;
            wait_d  = 4'(RD_LATENCY);
          end
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          state_d = ST_RDATA;
          mem_en  = 1'b1;
        end
      end
      ST_RDATA: begin
        beats_d = beats_q - 4'd1;
        if (beats_q == 4'd1) begin
          state_d = ST_GAP;
        end else begin
          mem_en   = 1'b1;
          mem_addr = word_q + 1'b1;
          word_d   = word_q + 1'b1;
        end
      end
      ST_WDATA: begin
        if (req_wdata_val) begin
          mem_en  = !err_q;
          mem_we  = !err_q;
          word_d  = word_q + 1'b1;
          beats_d = beats_q - 4'd1;
          if (beats_q == 4'd1) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      beats_q <= '0;
      wait_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
    end
  end

  l2_resp_mem #(
    .WORDS (MEM_WORDS),
    .AW    (MAW),
    .DW    (L2_DATA_WIDTH),
    .SW    (L2_STRB_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .rdata (mem_rdata)
  );

  // Response outputs decode straight from state; data is zero off-beat.
  always_comb begin
    resp_rdata_val = (state_q == ST_RDATA);
    resp_val       = (state_q == ST_RESP) || (resp_rdata_val && beats_q == 4'd1);
    resp_err       = (state_q == ST_RESP) && err_q;
    resp_rdata     = resp_rdata_val ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_l2_req_responder.sv
// Scoreboard bench for l2_req_responder; covers L2_RESP_ERR_INJ_EN when defined.
module tb_l2_req_responder;

  localparam int RD_LAT = 2;
  localparam int NWORDS = 1024;

  logic        clk, rst;
  logic        req_val, req_nc, req_wdata_val;
  logic [1:0]  req_cmd;
  logic [2:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_val, resp_err, resp_rdata_val;
  logic [31:0] resp_rdata;
`ifdef L2_RESP_ERR_INJ_EN
  logic        err_inject;
`endif

  typedef struct {
    int          cyc;
    logic        rdv;
    logic [31:0] data;
    logic        val;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [NWORDS];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  l2_req_responder #(
    .MEM_WORDS  (NWORDS),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef L2_RESP_ERR_INJ_EN
    .err_inject     (err_inject),
`endif
    .req_val        (req_val),
    .req_nc         (req_nc),
    .req_cmd        (req_cmd),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata_val  (req_wdata_val),
    .req_wdata      (req_wdata),
    .req_wstrb      (req_wstrb),
    .resp_val       (resp_val),
    .resp_err       (resp_err),
    .resp_rdata_val (resp_rdata_val),
    .resp_rdata     (resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Output monitor: every active output cycle must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!resp_rdata_val) chk("rdata_zero_offbeat", resp_rdata, 32'h0);
    if (!resp_val) chk("err_without_val", {31'h0, resp_err}, 32'h0);
    if (resp_val || resp_rdata_val) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", {30'h0, resp_val, resp_rdata_val}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("out_cycle", 32'(cyc), 32'(e.cyc));
        chk("rdata_val", {31'h0, resp_rdata_val}, {31'h0, e.rdv});
        chk("rdata", resp_rdata, e.data);
        chk("resp_val", {31'h0, resp_val}, {31'h0, e.val});
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
      end
    end
  end

  function automatic int nbeats(input int s);
    if (s <= 2 || s > 5) return 1;
    return 1 << (s - 2);
  endfunction

  function automatic void push_rd(input int c0, input logic [2:0] size,
                                  input logic [15:0] addr, input logic err);
    exp_t e;
    int   nb, w;
    if (err) begin
      e.cyc = c0 + 1; e.rdv = 1'b0; e.data = 32'h0; e.val = 1'b1; e.err = 1'b1;
      sbq.push_back(e);
    end else begin
      nb = nbeats(int'(size));
      w  = int'(addr[11:2]);
      for (int i = 0; i < nb; i++) begin
        e.cyc = c0 + 1 + RD_LAT + i; e.rdv = 1'b1; e.data = model[w + i];
        e.val = (i == nb - 1); e.err = 1'b0;
        sbq.push_back(e);
      end
    end
  endfunction

  task automatic wait_resp();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = resp_val;
    end
    if (!got) chk("resp_timeout", {31'h0, got}, 32'h1);
  endtask

  task automatic do_rd(input logic [1:0] cmd, input logic [2:0] size, input logic [15:0] addr,
                       input logic nc, input logic err, input logic hold);
    @(posedge clk); #1;
    req_val = 1'b1; req_cmd = cmd; req_size = size; req_addr = addr; req_nc = nc;
    push_rd(cyc, size, addr, err);
    wait_resp();
    if (hold) begin
      // request stays up through GAP; the repeat capture lands two cycles later
      push_rd(cyc + 2, size, addr, err);
      wait_resp();
    end
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic do_wr(input logic [2:0] size, input logic [15:0] addr, input logic nc,
                       input logic err, input logic [31:0] base, input logic [3:0] strb,
                       input int stall_at);
    exp_t e;
    int   nb, w;
    nb = nbeats(int'(size));
    w  = int'(addr[11:2]);
    @(posedge clk); #1;
    req_val = 1'b1; req_cmd = 2'b01; req_size = size; req_addr = addr; req_nc = nc;
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      if (i == stall_at) begin
        req_wdata_val = 1'b0;
        @(posedge clk); #1;
      end
      req_wdata_val = 1'b1; req_wdata = base + 32'(i); req_wstrb = strb;
      if (!err) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[w + i][8*b +: 8] = req_wdata[8*b +: 8];
      end
      if (i == nb - 1) begin
        e.cyc = cyc + 1; e.rdv = 1'b0; e.data = 32'h0; e.val = 1'b1; e.err = err;
        sbq.push_back(e);
      end
    end
    @(posedge clk); #1;
    req_wdata_val = 1'b0;
    wait_resp();
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   c0;
    rst = 1'b1; req_val = 1'b0; req_nc = 1'b0; req_cmd = 2'b00; req_size = 3'd0;
    req_addr = 16'h0; req_wdata_val = 1'b0; req_wdata = 32'h0; req_wstrb = 4'h0;
`ifdef L2_RESP_ERR_INJ_EN
    err_inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_val", {31'h0, resp_val}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_rdata_val", {31'h0, resp_rdata_val}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single word write/read, then a sub-word read of the same word
    do_wr(3'd2, 16'h0010, 1'b0, 1'b0, 32'hDEADBEEF, 4'hF, -1);
    do_rd(2'b00, 3'd2, 16'h0010, 1'b0, 1'b0, 1'b0);
    do_rd(2'b00, 3'd0, 16'h0013, 1'b0, 1'b0, 1'b0);

    // line fill with a stalled beat, then line read
    do_wr(3'd5, 16'h0040, 1'b0, 1'b0, 32'h1, 4'hF, 3);
    do_rd(2'b00, 3'd5, 16'h0040, 1'b0, 1'b0, 1'b0);

    // strobed merge
    do_wr(3'd2, 16'h0020, 1'b0, 1'b0, 32'h11111111, 4'hF, -1);
    do_wr(3'd2, 16'h0020, 1'b0, 1'b0, 32'hAABBCCDD, 4'h5, -1);
    do_rd(2'b00, 3'd2, 16'h0020, 1'b0, 1'b0, 1'b0);
    chk("strobe_model", model[8], 32'h11BB11DD);

    // 8-byte and top-of-memory line
    do_wr(3'd3, 16'h0008, 1'b0, 1'b0, 32'hC0DE0000, 4'hF, -1);
    do_rd(2'b00, 3'd3, 16'h0008, 1'b0, 1'b0, 1'b0);
    do_wr(3'd5, 16'h0FE0, 1'b0, 1'b0, 32'h00000100, 4'hF, -1);
    do_rd(2'b00, 3'd5, 16'h0FE0, 1'b0, 1'b0, 1'b0);

    // read-side errors
    do_rd(2'b10, 3'd2, 16'h0010, 1'b0, 1'b1, 1'b0);
    do_rd(2'b11, 3'd2, 16'h0010, 1'b0, 1'b1, 1'b0);
    do_rd(2'b00, 3'd6, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_rd(2'b00, 3'd7, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_rd(2'b00, 3'd4, 16'h0044, 1'b0, 1'b1, 1'b0);
    do_rd(2'b00, 3'd1, 16'h0011, 1'b0, 1'b1, 1'b0);
    do_rd(2'b00, 3'd3, 16'h0040, 1'b1, 1'b1, 1'b0);
    do_rd(2'b00, 3'd2, 16'h1000, 1'b0, 1'b1, 1'b0);
    do_rd(2'b00, 3'd5, 16'h1000, 1'b0, 1'b1, 1'b0);
    do_rd(2'b00, 3'd2, 16'h0010, 1'b1, 1'b0, 1'b0);

    // write-side errors must leave memory untouched
    do_wr(3'd2, 16'h0000, 1'b0, 1'b0, 32'h12345678, 4'hF, -1);
    do_wr(3'd3, 16'h0040, 1'b1, 1'b1, 32'hBAD00000, 4'hF, -1);
    do_wr(3'd2, 16'h1000, 1'b0, 1'b1, 32'hBAD10000, 4'hF, -1);
    do_rd(2'b00, 3'd5, 16'h0040, 1'b0, 1'b0, 1'b0);
    do_rd(2'b00, 3'd2, 16'h0000, 1'b0, 1'b0, 1'b0);

    // req_val held through GAP
    do_rd(2'b00, 3'd2, 16'h0010, 1'b0, 1'b0, 1'b1);

    // reset in RDATA after three beats
    @(posedge clk); #1;
    req_val = 1'b1; req_cmd = 2'b00; req_size = 3'd5; req_addr = 16'h0040; req_nc = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      e.cyc = c0 + 1 + RD_LAT + i; e.rdv = 1'b1; e.data = model[16 + i];
      e.val = 1'b0; e.err = 1'b0;
      sbq.push_back(e);
    end
    repeat (RD_LAT + 3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; req_val = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_resp_val", {31'h0, resp_val}, 32'h0);
    chk("midrst_rdata_val", {31'h0, resp_rdata_val}, 32'h0);
    chk("midrst_rdata", resp_rdata, 32'h0);
    chk("midrst_resp_err", {31'h0, resp_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    do_rd(2'b00, 3'd5, 16'h0040, 1'b0, 1'b0, 1'b0);

`ifdef L2_RESP_ERR_INJ_EN
    err_inject = 1'b1;
    do_rd(2'b00, 3'd2, 16'h0010, 1'b0, 1'b1, 1'b0);
    err_inject = 1'b0;
    do_rd(2'b00, 3'd2, 16'h0010, 1'b0, 1'b0, 1'b0);
`endif

    repeat (5) @(posedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
